// File: rtl/lc3_pkg.sv
// lc3_pkg: shared definitions for the LC-3 instruction sequencer.
//   - opcode constants (ir[15:12])
//   - FSM state encoding (visible on state_out)
//   - HALT trap vector and wait-timeout limit
//   - op_class_t: one-hot-ish opcode classification from lc3_op_decode
package lc3_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FETCH      = 3'd1,
    S_FETCH_WAIT = 3'd2,
    S_DECODE     = 3'd3,
    S_EXECUTE    = 3'd4,
    S_MEM        = 3'd5,
    S_MEM_WAIT   = 3'd6,
    S_WB         = 3'd7
  } state_e;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RES  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  localparam logic [7:0] HALT_VEC    = 8'h25;
  localparam logic [7:0] TIMEOUT_LIM = 8'd255;

  typedef struct packed {
    logic alu;       // ADD/AND/NOT/LEA: writeback with condition codes
    logic jsr;       // writeback without condition codes
    logic load;      // LD/LDR/LDI
    logic store;     // ST/STR/STI
    logic indirect;  // LDI/STI: extra pointer read first
    logic branch;    // BR/JMP: straight to boundary
    logic halt;      // TRAP x25
    logic illegal;   // other TRAP, RTI, reserved
  } op_class_t;

endpackage

// File: rtl/lc3_op_decode.sv
// lc3_op_decode: combinational opcode classifier.
//   op       in  4  ir[15:12]
//   trap_vec in  8  ir[7:0], only meaningful for TRAP
//   cls      out    classification flags (op_class_t)
module lc3_op_decode
  import lc3_pkg::*;
(
  input  logic [3:0] op,
  input  logic [7:0] trap_vec,
  output op_class_t  cls
);

  always_comb begin
    cls = '0;
    unique case (op)
      OP_ADD, OP_AND, OP_NOT, OP_LEA: cls.alu = 1'b1;
      OP_JSR:                         cls.jsr = 1'b1;
      OP_LD, OP_LDR:                  cls.load = 1'b1;
      OP_LDI: begin cls.load = 1'b1;  cls.indirect = 1'b1; end
      OP_ST, OP_STR:                  cls.store = 1'b1;
      OP_STI: begin cls.store = 1'b1; cls.indirect = 1'b1; end
      OP_BR, OP_JMP:                  cls.branch = 1'b1;
      OP_TRAP: begin
        if (trap_vec == HALT_VEC) cls.halt = 1'b1;
        else                      cls.illegal = 1'b1;
      end
      OP_RTI, OP_RES:                 cls.illegal = 1'b1;
      default:                        cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/lc3_controller.sv
// lc3_controller: LC-3 instruction sequencing FSM.
//   clk, rst (sync, active high), run (stop at instruction boundary when 0)
//   instr_in / mem_ready: memory return path
//   fetch_start, decode_en, exec_en, wb_en, nzp_we: one-cycle stage enables
//   mem_start/mem_wr/mem_indirect: data access request
//   ir_out, state_out, halted (sticky), illegal_op, bus_err (pulses)
// All outputs are flops computed from the next state, so each enable is
// high exactly while the FSM sits in the matching state.
module lc3_controller
  import lc3_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] instr_in,
  input  logic        mem_ready,
  output logic        fetch_start,
  output logic        decode_en,
  output logic        exec_en,
  output logic        wb_en,
  output logic        nzp_we,
  output logic        mem_start,
  output logic        mem_wr,
  output logic        mem_indirect,
  output logic [15:0] ir_out,
  output logic [2:0]  state_out,
  output logic        halted,
  output logic        illegal_op,
  output logic        bus_err
);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        ind_q, ind_d;     // pointer round of LDI/STI still pending
  logic        halted_q, halted_d;
  logic        illegal_q, illegal_d;
  logic        bus_err_q, bus_err_d;
  logic        fetch_q, decode_q, exec_q, wb_q, nzp_q, mstart_q, mwr_q, mind_q;
  state_e      boundary;
  op_class_t   cls;

  lc3_op_decode u_dec (
    .op       (ir_q[15:12]),
    .trap_vec (ir_q[7:0]),
    .cls      (cls)
  );

  assign boundary = run ? S_FETCH : S_IDLE;

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    cnt_d     = cnt_q;
    ind_d     = ind_q;
    halted_d  = halted_q;
    illegal_d = 1'b0;
    bus_err_d = 1'b0;
    unique case (state_q)
      S_IDLE:    if (run && !halted_q) state_d = S_FETCH;
      S_FETCH: begin
        cnt_d   = '0;
        state_d = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        if (mem_ready) begin
          ir_d    = instr_in;
          state_d = S_DECODE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          // counter would reach the limit with no completion: give up
          if (cnt_q == TIMEOUT_LIM - 8'd1) begin
            bus_err_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      S_DECODE:  state_d = S_EXECUTE;
      S_EXECUTE: begin
        if (cls.halt) begin
          halted_d = 1'b1;
          state_d  = S_IDLE;
        end else if (cls.illegal) begin
          illegal_d = 1'b1;
          state_d   = boundary;
        end else if (cls.alu || cls.jsr) begin
          state_d = S_WB;
        end else if (cls.load || cls.store) begin
          ind_d   = cls.indirect;
          state_d = S_MEM;
        end else if (cls.branch) begin
          state_d = boundary;
        end else begin
          state_d = boundary;
        end
      end
      S_MEM: begin
        cnt_d   = '0;
        state_d = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        if (mem_ready) begin
          if (ind_q) begin
            ind_d   = 1'b0;
            state_d = S_MEM;
          end else begin
            state_d = cls.load ? S_WB : boundary;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == TIMEOUT_LIM - 8'd1) begin
            bus_err_d = 1'b1;
            ind_d     = 1'b0;
            state_d   = S_IDLE;
          end
        end
      end
      S_WB:      state_d = boundary;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      cnt_q     <= '0;
      ind_q     <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      fetch_q   <= 1'b0;
      decode_q  <= 1'b0;
      exec_q    <= 1'b0;
      wb_q      <= 1'b0;
      nzp_q     <= 1'b0;
      mstart_q  <= 1'b0;
      mwr_q     <= 1'b0;
      mind_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      cnt_q     <= cnt_d;
      ind_q     <= ind_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
      fetch_q   <= (state_d == S_FETCH);
      decode_q  <= (state_d == S_DECODE);
      exec_q    <= (state_d == S_EXECUTE);
      wb_q      <= (state_d == S_WB);
      nzp_q     <= (state_d == S_WB) && !cls.jsr;
      mstart_q  <= (state_d == S_MEM);
      // the pointer round is always a read; the data round follows the opcode
      mwr_q     <= (state_d == S_MEM) && !ind_d && cls.store;
      mind_q    <= (state_d == S_MEM) && ind_d;
    end
  end

  assign fetch_start  = fetch_q;
  assign decode_en    = decode_q;
  assign exec_en      = exec_q;
  assign wb_en        = wb_q;
  assign nzp_we       = nzp_q;
  assign mem_start    = mstart_q;
  assign mem_wr       = mwr_q;
  assign mem_indirect = mind_q;
  assign ir_out       = ir_q;
  assign state_out    = state_q;
  assign halted       = halted_q;
  assign illegal_op   = illegal_q;
  assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_lc3_controller.sv
// tb_lc3_controller: scoreboard bench. Stimulus pushes expected output
// events (kind, cycle gap from previous event, qualifiers); a monitor pops
// and compares whenever the DUT pulses fetch/mem/wb/bus_err/illegal_op.
// A responder process models memory with a programmable latency.
module tb_lc3_controller;

  localparam int K_F = 0, K_M = 1, K_W = 2, K_B = 3, K_I = 4;

  logic        clk = 1'b0, rst = 1'b1, run = 1'b0, mem_ready = 1'b0;
  logic [15:0] instr_in = 16'h0;
  logic        fetch_start, decode_en, exec_en, wb_en, nzp_we;
  logic        mem_start, mem_wr, mem_indirect, halted, illegal_op, bus_err;
  logic [15:0] ir_out;
  logic [2:0]  state_out;

  lc3_controller dut (
    .clk(clk), .rst(rst), .run(run), .instr_in(instr_in), .mem_ready(mem_ready),
    .fetch_start(fetch_start), .decode_en(decode_en), .exec_en(exec_en),
    .wb_en(wb_en), .nzp_we(nzp_we), .mem_start(mem_start), .mem_wr(mem_wr),
    .mem_indirect(mem_indirect), .ir_out(ir_out), .state_out(state_out),
    .halted(halted), .illegal_op(illegal_op), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    int          dt;    // cycles since previous event, <0 = unchecked
    logic        wr;
    logic        ind;
    logic        nzp;
    logic [15:0] ir;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] prog[$];
  int checks = 0, errors = 0;
  int cyc = 0, last_cyc = 0;
  int lat = 2;      // wait cycles before mem_ready; <0 = never answer
  int cd = -1;
  int evn[5] = '{0, 0, 0, 0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic ex(input int k, input int dt, input logic wr, input logic ind,
                    input logic nzp, input logic [15:0] ir);
    exp_t e;
    e.kind = k; e.dt = dt; e.wr = wr; e.ind = ind; e.nzp = nzp; e.ir = ir;
    sb.push_back(e);
  endtask

  task automatic observe(input int k);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: kind %0d at cycle %0d, none expected", k, cyc);
    end else begin
      e = sb.pop_front();
      chk("ev_kind", k, e.kind);
      if (e.dt >= 0) chk("ev_gap", cyc - last_cyc, e.dt);
      if (k == K_M) begin
        chk("mem_wr", mem_wr, e.wr);
        chk("mem_indirect", mem_indirect, e.ind);
      end
      if (k == K_W) begin
        chk("nzp_we", nzp_we, e.nzp);
        chk("wb_ir", ir_out, e.ir);
      end
      if (k == K_B) chk("buserr_state", state_out, 0);
    end
    last_cyc = cyc;
    evn[k]++;
  endtask

  // monitor
  initial forever begin
    @(posedge clk); #1;
    if (!rst) begin
      if (bus_err)     observe(K_B);
      if (illegal_op)  observe(K_I);
      if (fetch_start) observe(K_F);
      if (mem_start)   observe(K_M);
      if (wb_en)       observe(K_W);
    end
  end

  // memory responder
  initial forever begin
    @(posedge clk); #1;
    mem_ready = 1'b0;
    if (rst) cd = -1;
    else if (fetch_start || mem_start) begin
      if (fetch_start && prog.size() > 0) instr_in = prog.pop_front();
      cd = lat;
    end else if (cd > 0) cd--;
    else if (cd == 0) begin
      mem_ready = 1'b1;
      cd = -1;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, {fetch_start, decode_en, exec_en, wb_en, nzp_we, mem_start, mem_wr,
             mem_indirect, halted, illegal_op, bus_err}, 0);
    chk({nm, "_ir"}, ir_out, 16'h0000);
    chk({nm, "_state"}, state_out, 0);
  endtask

  task automatic wait_ev(input string nm, input int k, input int bound);
    int s = evn[k];
    int t = 0;
    while (evn[k] == s && t < bound) begin step(1); t++; end
    chk({nm, "_seen"}, evn[k] != s, 1);
  endtask

  initial begin
    // reset state
    step(3);
    chk_zero("reset");
    rst = 1'b0;
    step(3);
    chk("idle_no_run", state_out, 0);

    // program: ADD, AND, JSR, BR, reserved, LDI, STR, HALT
    prog = '{16'h1261, 16'h5020, 16'h4800, 16'h0E05, 16'hD000,
             16'hA402, 16'h7181, 16'hF025};
    ex(K_F, -1, 0, 0, 0, 0); ex(K_W, 6, 0, 0, 1, 16'h1261);
    ex(K_F,  1, 0, 0, 0, 0); ex(K_W, 6, 0, 0, 1, 16'h5020);
    ex(K_F,  1, 0, 0, 0, 0); ex(K_W, 6, 0, 0, 0, 16'h4800);
    ex(K_F,  1, 0, 0, 0, 0);
    ex(K_F,  6, 0, 0, 0, 0); ex(K_I, 6, 0, 0, 0, 0);
    ex(K_F,  0, 0, 0, 0, 0);
    ex(K_M,  6, 0, 1, 0, 0); ex(K_M, 4, 0, 0, 0, 0); ex(K_W, 4, 0, 0, 1, 16'hA402);
    ex(K_F,  1, 0, 0, 0, 0); ex(K_M, 6, 1, 0, 0, 0);
    ex(K_F,  4, 0, 0, 0, 0);
    run = 1'b1;
    begin
      int t = 0;
      while (halted !== 1'b1 && t < 300) begin step(1); t++; end
    end
    chk("halted_set", halted, 1);
    chk("halt_state", state_out, 0);
    step(20);  // any further fetch is flagged by the monitor
    chk("halted_sticky", halted, 1);
    chk("halt_state_hold", state_out, 0);
    run = 1'b0;
    rst = 1'b1;
    step(1);
    chk_zero("halt_reset");
    rst = 1'b0;
    step(2);

    // fetch timeout
    lat = -1;
    prog.push_back(16'h1261);
    ex(K_F, -1, 0, 0, 0, 0); ex(K_B, 256, 0, 0, 0, 0);
    run = 1'b1;
    wait_ev("to_fetch", K_F, 20);
    run = 1'b0;
    wait_ev("to_buserr", K_B, 400);
    chk("to_state", state_out, 0);
    step(5);
    chk("to_idle_hold", state_out, 0);
    lat = 2;

    // run drop during LD's MEM_WAIT
    prog.push_back(16'h2202);
    ex(K_F, -1, 0, 0, 0, 0); ex(K_M, 6, 0, 0, 0, 0); ex(K_W, 4, 0, 0, 1, 16'h2202);
    run = 1'b1;
    wait_ev("ld_mem", K_M, 40);
    step(1);
    run = 1'b0;
    wait_ev("ld_wb", K_W, 40);
    step(1);
    chk("ld_idle", state_out, 0);
    step(10);
    chk("ld_idle_hold", state_out, 0);

    // reset during DECODE
    prog.push_back(16'h1261);
    ex(K_F, -1, 0, 0, 0, 0);
    run = 1'b1;
    wait_ev("rd_fetch", K_F, 20);
    run = 1'b0;
    step(4);
    chk("rd_in_decode", state_out, 3);
    chk("rd_decode_en", decode_en, 1);
    rst = 1'b1;
    step(1);
    chk_zero("rd_reset");
    rst = 1'b0;
    step(5);
    chk("rd_idle", state_out, 0);

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
